// File: rtl/valu_pkg.sv
// Shared constants and state type for the vector ALU lane sequencer.
package valu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/valu_flag_accum.sv
// Per-beat reduction of lane ALU flags and the running {ovf,neg,zero,carry} accumulator.
module valu_flag_accum
    import valu_pkg::*;
#(
    parameter int P_UNITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 acc_en,
    input  logic                 scalar,
    input  logic [P_UNITS*4-1:0] lane_flags,
    output logic [3:0]           acc_flags
);

    logic beat_c;
    logic beat_z;
    logic beat_n;
    logic beat_v;

    // Scalar ops contribute only unit 0; zero is AND-reduced, the rest OR-reduced.
    always_comb begin
        beat_c = 1'b0;
        beat_z = 1'b1;
        beat_n = 1'b0;
        beat_v = 1'b0;
        for (int u = 0; u < P_UNITS; u++) begin
            if (!scalar || u == 0) begin
                beat_c = beat_c | lane_flags[u*4 + FLG_C];
                beat_z = beat_z & lane_flags[u*4 + FLG_Z];
                beat_n = beat_n | lane_flags[u*4 + FLG_N];
                beat_v = beat_v | lane_flags[u*4 + FLG_V];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_flags <= '0;
        end else if (clear) begin
            acc_flags        <= '0;
            acc_flags[FLG_Z] <= 1'b1;
        end else if (acc_en) begin
            acc_flags[FLG_C] <= acc_flags[FLG_C] | beat_c;
            acc_flags[FLG_Z] <= acc_flags[FLG_Z] & beat_z;
            acc_flags[FLG_N] <= acc_flags[FLG_N] | beat_n;
            acc_flags[FLG_V] <= acc_flags[FLG_V] | beat_v;
        end
    end

endmodule

// File: rtl/valu_lane_sequencer.sv
// Sequences one vector op over P_UNITS shared lane ALUs and buffers the result vector.
// Optional performance counters are enabled by defining VALU_SEQ_PERF_CNT_EN.
module valu_lane_sequencer
    import valu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int N_LANES = 8,
    parameter int P_UNITS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  in_opcode,
    input  logic                        in_scalar,
    input  logic [N_LANES*DATA_W-1:0]   in_a,
    input  logic [N_LANES*DATA_W-1:0]   in_b,
    output logic [P_UNITS*DATA_W-1:0]   alu_a,
    output logic [P_UNITS*DATA_W-1:0]   alu_b,
    output logic [2:0]                  alu_opcode,
    output logic                        alu_scalar,
    input  logic [P_UNITS*DATA_W-1:0]   alu_result,
    input  logic [P_UNITS*4-1:0]        alu_flags,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_LANES*DATA_W-1:0]   out_result,
    output logic [3:0]                  out_flags,
    output logic                        busy
`ifdef VALU_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_ops,
    output logic [31:0]                 perf_busy,
    output logic [31:0]                 perf_stall
`endif
);

    localparam int BEATS  = N_LANES / P_UNITS;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    generate
        if (N_LANES % P_UNITS != 0) begin : g_bad_cfg
            $error("valu_lane_sequencer: N_LANES must be a multiple of P_UNITS");
        end
    endgenerate

    seq_state_t                 state;
    seq_state_t                 state_nxt;
    logic [BEAT_W-1:0]          beat;
    logic [N_LANES*DATA_W-1:0]  lat_a;
    logic [N_LANES*DATA_W-1:0]  lat_b;
    logic                       accept;
    logic                       run_last;

    assign accept   = (state == IDLE) && in_valid;
    assign run_last = (state == RUN) && (alu_scalar || beat == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (run_last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accept clears the buffer; each RUN beat lands P_UNITS lane results in their slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat       <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            alu_opcode <= '0;
            alu_scalar <= 1'b0;
            out_result <= '0;
        end else if (accept) begin
            beat       <= '0;
            lat_a      <= in_a;
            lat_b      <= in_b;
            alu_opcode <= in_opcode;
            alu_scalar <= in_scalar;
            out_result <= '0;
        end else if (state == RUN) begin
            for (int u = 0; u < P_UNITS; u++) begin
                if (!alu_scalar || u == 0) begin
                    out_result[(int'(beat)*P_UNITS + u)*DATA_W +: DATA_W] <= alu_result[u*DATA_W +: DATA_W];
                end
            end
            beat <= run_last ? '0 : beat + 1'b1;
        end
    end

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        if (state == RUN) begin
            for (int u = 0; u < P_UNITS; u++) begin
                alu_a[u*DATA_W +: DATA_W] = lat_a[(int'(beat)*P_UNITS + u)*DATA_W +: DATA_W];
                alu_b[u*DATA_W +: DATA_W] = lat_b[(int'(beat)*P_UNITS + u)*DATA_W +: DATA_W];
            end
        end
    end

    valu_flag_accum #(
        .P_UNITS (P_UNITS)
    ) u_flag_accum (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .acc_en     (state == RUN),
        .scalar     (alu_scalar),
        .lane_flags (alu_flags),
        .acc_flags  (out_flags)
    );

`ifdef VALU_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops   <= '0;
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid && out_ready) perf_ops <= perf_ops + 32'd1;
            if (busy) perf_busy <= perf_busy + 32'd1;
            if (state == DONE && !out_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_valu_lane_sequencer.sv
// Self-checking bench for valu_lane_sequencer: behavioural lane ALUs, an op-level model and directed vectors.
module tb_valu_lane_sequencer;
    import valu_pkg::*;

    localparam int DW    = 16;
    localparam int NL    = 8;
    localparam int PU    = 2;
    localparam int BEATS = NL / PU;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_opcode;
    logic              in_scalar;
    logic [NL*DW-1:0]  in_a;
    logic [NL*DW-1:0]  in_b;
    logic [PU*DW-1:0]  alu_a;
    logic [PU*DW-1:0]  alu_b;
    logic [2:0]        alu_opcode;
    logic              alu_scalar;
    logic [PU*DW-1:0]  alu_result;
    logic [PU*4-1:0]   alu_flags;
    logic              out_valid;
    logic              out_ready;
    logic [NL*DW-1:0]  out_result;
    logic [3:0]        out_flags;
    logic              busy;
`ifdef VALU_SEQ_PERF_CNT_EN
    logic [31:0]       perf_ops;
    logic [31:0]       perf_busy;
    logic [31:0]       perf_stall;
`endif

    int checks   = 0;
    int failures = 0;

    valu_lane_sequencer #(
        .DATA_W  (DW),
        .N_LANES (NL),
        .P_UNITS (PU)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_scalar  (in_scalar),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_scalar (alu_scalar),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .busy       (busy)
`ifdef VALU_SEQ_PERF_CNT_EN
        ,
        .perf_ops   (perf_ops),
        .perf_busy  (perf_busy),
        .perf_stall (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q8.8 lane ALU: returns {ovf,neg,zero,carry,result}; invalid opcodes give 0.
    function automatic logic [19:0] lane_alu(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        logic [16:0] s;
        logic [31:0] p;
        logic [15:0] r;
        logic        c;
        logic        v;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        p = '0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[15:0];
                c = s[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            OP_MUL: begin
                p = $signed(a) * $signed(b);
                r = p[23:8];
                v = (p[31:23] != {9{p[23]}});
            end
            default: ;
        endcase
        return {v, r[15], (r == 16'h0000), c, r};
    endfunction

    always_comb begin
        alu_result = '0;
        alu_flags  = '0;
        for (int u = 0; u < PU; u++) begin
            {alu_flags[u*4 +: 4], alu_result[u*DW +: DW]} =
                lane_alu(alu_a[u*DW +: DW], alu_b[u*DW +: DW], alu_opcode);
        end
    end

    // Whole-op expectation: {flags, result vector} over the contributing elements.
    function automatic logic [NL*DW+3:0] model_op(input logic [NL*DW-1:0] a, input logic [NL*DW-1:0] b,
                                                  input logic [2:0] op, input logic sc);
        logic [NL*DW-1:0] res;
        logic [3:0]       fl;
        logic [19:0]      t;
        res = '0;
        fl  = 4'b0010;
        for (int e = 0; e < (sc ? 1 : NL); e++) begin
            t = lane_alu(a[e*DW +: DW], b[e*DW +: DW], op);
            res[e*DW +: DW] = t[15:0];
            fl[0] = fl[0] | t[16];
            fl[1] = fl[1] & t[17];
            fl[2] = fl[2] | t[18];
            fl[3] = fl[3] | t[19];
        end
        return {fl, res};
    endfunction

    int               m_phase;
    int               m_left;
    int               m_beat;
    logic [NL*DW-1:0] m_a;
    logic [NL*DW-1:0] m_b;
    logic [NL*DW-1:0] m_res;
    logic [3:0]       m_flags;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_left  <= 0;
            m_beat  <= 0;
            m_a     <= '0;
            m_b     <= '0;
            m_res   <= '0;
            m_flags <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    {m_flags, m_res} <= model_op(in_a, in_b, in_opcode, in_scalar);
                    m_a     <= in_a;
                    m_b     <= in_b;
                    m_left  <= in_scalar ? 1 : BEATS;
                    m_beat  <= 0;
                    m_phase <= 1;
                end
                1: begin
                    m_beat <= m_beat + 1;
                    m_left <= m_left - 1;
                    if (m_left == 1) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_output("in_ready", 128'(in_ready), 128'(m_phase == 0));
            check_output("busy", 128'(busy), 128'(m_phase != 0));
            check_output("out_valid", 128'(out_valid), 128'(m_phase == 2));
            if (m_phase == 1) begin
                check_output("alu_a", 128'(alu_a), 128'(m_a[m_beat*PU*DW +: PU*DW]));
                check_output("alu_b", 128'(alu_b), 128'(m_b[m_beat*PU*DW +: PU*DW]));
            end else begin
                check_output("alu_a_idle", 128'(alu_a), 128'(0));
                check_output("alu_b_idle", 128'(alu_b), 128'(0));
            end
            if (m_phase == 2) begin
                check_output("out_result", out_result, m_res);
                check_output("out_flags", 128'(out_flags), 128'(m_flags));
            end
        end
    end

    task automatic apply_stimulus(input logic [NL*DW-1:0] a, input logic [NL*DW-1:0] b,
                                  input logic [2:0] op, input logic sc,
                                  output int lat, output int runs);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_opcode = op;
        in_scalar = sc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat  = 1;
        runs = (busy && !out_valid) ? 1 : 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy && !out_valid) runs++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_output("idle_after_ready", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    endtask

    logic [NL*DW-1:0] va;
    logic [NL*DW-1:0] vb;
    logic [NL*DW-1:0] exp_add;
    int               lat;
    int               runs;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_scalar = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        fork
            begin
                #200000;
                $display("[TB] FAIL watchdog: simulation did not finish");
                $fatal(1, "[TB] watchdog expired");
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_outputs", 128'({in_ready, out_valid, busy}), 128'(3'b100));
        check_output("rst_result", out_result, 128'(0));
        check_output("rst_flags", 128'(out_flags), 128'(0));
        check_output("rst_alu", 128'({alu_a, alu_b, alu_opcode, alu_scalar}), 128'(0));
        rst = 1'b0;

        // Vector add: a[i]=0x0100*i, b[i]=0x0080.
        for (int i = 0; i < NL; i++) begin
            va[i*DW +: DW]      = 16'(16'h0100 * i);
            vb[i*DW +: DW]      = 16'h0080;
            exp_add[i*DW +: DW] = 16'(16'h0100 * i + 16'h0080);
        end
        apply_stimulus(va, vb, OP_ADD, 1'b0, lat, runs);
        check_output("add_latency", 128'(lat), 128'(5));
        check_output("add_elem7", 128'(out_result[7*DW +: DW]), 128'(16'h0780));
        check_output("add_vector", out_result, exp_add);
        check_output("add_zero_neg", 128'({out_flags[FLG_Z], out_flags[FLG_N]}), 128'(2'b00));
        drain();

        // Scalar mul 2.0 * 1.5; other elements carry nonzero data that must be ignored.
        for (int i = 0; i < NL; i++) begin
            va[i*DW +: DW] = (i == 0) ? 16'h0200 : 16'h0100;
            vb[i*DW +: DW] = 16'h0180;
        end
        apply_stimulus(va, vb, OP_MUL, 1'b1, lat, runs);
        check_output("mul_latency", 128'(lat), 128'(2));
        check_output("mul_run_cycles", 128'(runs), 128'(1));
        check_output("mul_elem0", 128'(out_result[DW-1:0]), 128'(16'h0300));
        check_output("mul_upper_zero", 128'(out_result[NL*DW-1:DW]), 128'(0));
        drain();

        // Sub equal operands, then one element going negative.
        for (int i = 0; i < NL; i++) begin
            va[i*DW +: DW] = 16'h1234;
            vb[i*DW +: DW] = 16'h1234;
        end
        apply_stimulus(va, vb, OP_SUB, 1'b0, lat, runs);
        check_output("sub_eq_result", out_result, 128'(0));
        check_output("sub_eq_zero_neg", 128'({out_flags[FLG_Z], out_flags[FLG_N]}), 128'(2'b10));
        drain();
        va[3*DW +: DW] = 16'h0000;
        vb[3*DW +: DW] = 16'h0100;
        apply_stimulus(va, vb, OP_SUB, 1'b0, lat, runs);
        check_output("sub_neg_elem3", 128'(out_result[3*DW +: DW]), 128'(16'hFF00));
        check_output("sub_neg_zero_neg", 128'({out_flags[FLG_Z], out_flags[FLG_N]}), 128'(2'b01));
        drain();

        // Backpressure in DONE with a competing in_valid.
        for (int i = 0; i < NL; i++) begin
            va[i*DW +: DW] = 16'(16'h0100 * i);
            vb[i*DW +: DW] = 16'h0080;
        end
        apply_stimulus(va, vb, OP_ADD, 1'b0, lat, runs);
        in_valid  = 1'b1;
        in_a      = {NL{16'h7777}};
        in_opcode = OP_SUB;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check_output("bp_result", out_result, exp_add);
            check_output("bp_handshake", 128'({in_ready, out_valid}), 128'(2'b01));
        end
        in_valid = 1'b0;
        drain();

        // Asynchronous reset during beat 2.
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_a      = va;
        in_b      = vb;
        in_opcode = OP_ADD;
        in_scalar = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("abort_outputs", 128'({in_ready, out_valid, busy}), 128'(3'b100));
        check_output("abort_result", out_result, 128'(0));
        #1;
        rst = 1'b0;
        apply_stimulus(va, vb, OP_ADD, 1'b0, lat, runs);
        check_output("post_rst_latency", 128'(lat), 128'(5));
        check_output("post_rst_vector", out_result, exp_add);
        drain();

        // Invalid opcode: lanes return 0.
        apply_stimulus(va, vb, 3'b111, 1'b0, lat, runs);
        check_output("inv_result", out_result, 128'(0));
        check_output("inv_flags", 128'(out_flags), 128'(4'b0010));
        drain();
`ifdef VALU_SEQ_PERF_CNT_EN
        check_output("perf_ops", 128'(perf_ops), 128'(2));
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/valu_lane_sequencer.md
Name: valu_lane_sequencer

Overview:
- Sequences one vector ALU operation across N_LANES 16-bit elements using a smaller pool of P_UNITS combinational lane ALUs.
- Each ALU lane has the interface data_a/data_b/opcode/flag_scalar/result/flags.
- Accepts a whole vector op via valid/ready, feeds P_UNITS lanes per beat, and collects the results into an output buffer.
- Presents the full result vector plus aggregated flags via valid/ready.
- Sits between the decode/register-read stage and writeback in the vector datapath.

Parameters:
- DATA_W, 16, element width (Q8.8 fixed point, matching the lane ALU).
- N_LANES, 8, elements per vector.
- P_UNITS, 2, physical lane ALUs driven per beat. N_LANES % P_UNITS must equal 0; otherwise elaboration fails.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  vector op offered.
- in_ready  out  1  sequencer can accept an op.
- in_opcode  in  3  000 add, 001 sub, 010 mul, others invalid.
- in_scalar  in  1  scalar op; only element 0 is computed.
- in_a  in  N_LANES*DATA_W  operand A vector; element i is at bits [i*16 +: 16].
- in_b  in  N_LANES*DATA_W  operand B vector.
- alu_a  out  P_UNITS*DATA_W  operands to the lane ALUs.
- alu_b  out  P_UNITS*DATA_W  operands to the lane ALUs.
- alu_opcode  out  3  latched opcode.
- alu_scalar  out  1  latched scalar flag.
- alu_result  in  P_UNITS*DATA_W  combinational lane results.
- alu_flags  in  P_UNITS*4  per lane {ovf,neg,zero,carry} = bits [3:0] as {3,2,1,0}.
- out_valid  out  1  result vector ready.
- out_ready  in  1  consumer accepts.
- out_result  out  N_LANES*DATA_W  result vector.
- out_flags  out  4  aggregated flags.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - out_result=0, out_flags=0.
  - Beat counter=0, latched operands/opcode/scalar=0.
  - Reset asserted mid-operation aborts the op immediately: no output, buffer cleared.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a, in_b, in_opcode, in_scalar.
  - Clear the result buffer and flag accumulators. Set beat=0. Go to RUN.
- RUN:
  - in_ready=0.
  - alu_a/alu_b carry latched elements [beat*P_UNITS +: P_UNITS].
  - Each cycle, alu_result is written into buffer slots [beat*P_UNITS +: P_UNITS] and flags are accumulated.
  - Then beat increments.
  - Non-scalar: RUN lasts BEATS = N_LANES/P_UNITS cycles. On the last beat, go to DONE.
  - Scalar: exactly 1 beat. Only unit 0 / element 0 is written and accumulated. All other buffer elements remain 0. Go to DONE.
- DONE:
  - out_valid=1. out_result and out_flags are stable while out_valid && !out_ready.
  - On out_ready, go to IDLE the following cycle. No back-to-back accept in the same cycle.
- Latency: accept edge to out_valid is BEATS+1 cycles (scalar: 2).
- alu_a/alu_b are driven 0 outside RUN.
- alu_opcode/alu_scalar hold their latched values.
- Flag aggregation over the written elements only:
  - carry = OR.
  - neg = OR.
  - ovf = OR.
  - zero = AND (all contributing results zero).
  - Zero accumulator initialises to 1.
  - Carry/neg/ovf accumulators initialise to 0.
- Invalid opcode: sequenced normally. The lane ALU returns 0, so out_result=0 and zero=1.
- in_valid while not in IDLE is ignored; the upstream must hold it.

Optional Feature:
- Macro VALU_SEQ_PERF_CNT_EN.
- When defined, adds three outputs, all 32-bit wrap-around counters reset to 0:
  - perf_ops: increments on each out_valid && out_ready.
  - perf_busy: increments every cycle busy=1.
  - perf_stall: increments each DONE cycle with out_ready=0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package valu_pkg holds:
  - Opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010.
  - Flag bit indices FLG_C=0, FLG_Z=1, FLG_N=2, FLG_V=3.
  - Enum seq_state_t {IDLE, RUN, DONE}.
- One natural sub-module: valu_flag_accum, which holds the per-beat OR/AND reduction and the accumulator registers.

Test Plan:
- Vector add, N_LANES=8, P_UNITS=2: a[i]=0x0100*i, b[i]=0x0080.
  - Expect out_valid 5 cycles after accept and out_result[i]=0x0100*i+0x0080.
  - Expect out_flags zero=0, neg=0.
- Scalar mul: a[0]=0x0200 (2.0), b[0]=0x0180 (1.5), in_scalar=1.
  - Expect out_valid 2 cycles after accept and out_result[0]=0x0300.
  - Expect elements 1..7 = 0 and only 1 RUN cycle.
- Sub with all a[i]=b[i]=0x1234: expect all results 0, zero=1, neg=0.
  - Then a[3]=0x0000, b[3]=0x0100: expect result[3]=0xFF00, neg=1, zero=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - Expect out_result stable, in_ready=0, in_valid ignored.
  - Expect IDLE the cycle after out_ready=1.
- Assert rst during beat 2 of RUN.
  - Expect out_valid=0, busy=0, out_result=0 immediately (asynchronous).
  - A next op after release completes correctly.
- Invalid opcode 3'b111: expect out_result all 0, zero=1, and perf_ops increments by 1 when VALU_SEQ_PERF_CNT_EN is defined.
